// File: rtl/seg7_scanner_if.sv
// Display bus between the CPU-side register writer and the 8-digit 7-segment scanner.
interface seg7_scanner_if;
  logic [31:0] hex;
  logic [7:0]  dp_mask;
  logic        load;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  modport master (output hex, dp_mask, load, input an, seg, dp, frame_done);
  modport slave  (input hex, dp_mask, load, output an, seg, dp, frame_done);
endinterface

// File: rtl/seg7_scanner.sv
// Time-multiplexed 8-digit 7-segment scanner; new words take effect only at frame boundaries.
// Optional leading-zero blanking: define SEG7_SCANNER_LZB_EN.
module seg7_scanner #(
  parameter int CLK_DIV = 16
) (
  input  logic          clk,
  input  logic          reset,
  seg7_scanner_if.slave bus
);
  localparam int PW = $clog2(CLK_DIV);

  typedef struct packed {
    logic [31:0] hex;
    logic [7:0]  dpMask;
  } dispWord_t;

  logic [PW-1:0] prescaler;
  logic [2:0]    digit, digitNext;
  logic          tick, wrap;
  dispWord_t     pending, display, dispNext;
  logic          pendingValid;
  logic [3:0]    nibble;
  logic [7:0]    anNext;
  logic [6:0]    segNext;
  logic          dpNext;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h40;  4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;  4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;  4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;  4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;  4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;  4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;  4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;  default: decode = 7'h0E;
    endcase
  endfunction

  assign tick      = prescaler == PW'(CLK_DIV - 1);
  assign wrap      = tick && (digit == 3'd7);
  assign digitNext = tick ? digit + 3'd1 : digit;
  // Outputs for the first digit of a frame must already reflect the word committed on that edge.
  assign dispNext  = (wrap && pendingValid) ? pending : display;
  assign nibble    = dispNext.hex[4*digitNext +: 4];

`ifdef SEG7_SCANNER_LZB_EN
  logic [2:0] msd;
  logic       blank;

  always_comb begin
    msd = 3'd0;
    for (int i = 1; i < 8; i++)
      if (dispNext.hex[4*i +: 4] != 4'h0) msd = 3'(i);
  end

  // Digit 0 is never above msd, so an all-zero word still shows a single "0".
  assign blank = digitNext > msd;

  always_comb begin
    anNext  = ~(8'b1 << digitNext);
    segNext = decode(nibble);
    dpNext  = ~dispNext.dpMask[digitNext];
    if (blank) begin
      anNext  = 8'hFF;
      segNext = 7'h7F;
      dpNext  = 1'b1;
    end
  end
`else
  always_comb begin
    anNext  = ~(8'b1 << digitNext);
    segNext = decode(nibble);
    dpNext  = ~dispNext.dpMask[digitNext];
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler      <= '0;
      digit          <= '0;
      pending        <= '0;
      pendingValid   <= 1'b0;
      display        <= '0;
      bus.an         <= 8'hFE;
      bus.seg        <= 7'h40;
      bus.dp         <= 1'b1;
      bus.frame_done <= 1'b0;
    end else begin
      prescaler      <= tick ? '0 : prescaler + 1'b1;
      digit          <= digitNext;
      display        <= dispNext;
      bus.frame_done <= wrap;
      // A load on the commit edge lands in pending after the old word has moved to display.
      if (bus.load) begin
        pending      <= {bus.hex, bus.dp_mask};
        pendingValid <= 1'b1;
      end else if (wrap) begin
        pendingValid <= 1'b0;
      end
      if (tick) begin
        bus.an  <= anNext;
        bus.seg <= segNext;
        bus.dp  <= dpNext;
      end
    end
  end
endmodule

// File: tb/tb_seg7_scanner.sv
// Directed bench for seg7_scanner with a frame-level reference model checked every cycle.
module tb_seg7_scanner;
  localparam int CLK_DIV = 4;
  localparam int FRAME   = 8 * CLK_DIV;
  localparam logic [6:0] SEGT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic cmpEn = 1'b0;

  seg7_scanner_if bus ();
  seg7_scanner #(.CLK_DIV(CLK_DIV)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Reference: cycles since reset release fix the digit; the word shown changes only at frame multiples.
  int          mCyc = 0;
  logic [39:0] mPend = '0;
  logic        mPendV = 1'b0;
  logic [39:0] mDisp = '0;

  always @(posedge clk) begin
    if (reset) begin
      mCyc   <= 0;
      mPend  <= '0;
      mPendV <= 1'b0;
      mDisp  <= '0;
    end else begin
      mCyc <= mCyc + 1;
      if (((mCyc + 1) % FRAME) == 0 && mPendV) mDisp <= mPend;
      if (bus.load) begin
        mPend  <= {bus.hex, bus.dp_mask};
        mPendV <= 1'b1;
      end else if (((mCyc + 1) % FRAME) == 0) begin
        mPendV <= 1'b0;
      end
    end
  end

  function automatic logic [16:0] expect_out(int cyc, logic [39:0] w);
    int dig, top;
    logic [7:0] a;
    logic [6:0] s;
    logic d, f;
    dig = (cyc / CLK_DIV) % 8;
    a = ~(8'b1 << dig);
    s = SEGT[w[8 + 4*dig +: 4]];
    d = ~w[dig];
    f = (cyc != 0) && (cyc % FRAME == 0);
    top = 0;
    for (int i = 0; i < 8; i++) if (w[8 + 4*i +: 4] != 4'h0) top = i;
`ifdef SEG7_SCANNER_LZB_EN
    if (dig > top) begin
      a = 8'hFF;
      s = 7'h7F;
      d = 1'b1;
    end
`endif
    return {a, s, d, f};
  endfunction

  always @(negedge clk) begin
    logic [16:0] e;
    if (cmpEn) begin
      e = expect_out(mCyc, mDisp);
      total++;
      if ({bus.an, bus.seg, bus.dp, bus.frame_done} !== e) begin
        bad++;
        $display("FAIL model cyc=%0d got an=%h seg=%h dp=%b fd=%b want an=%h seg=%h dp=%b fd=%b",
                 mCyc, bus.an, bus.seg, bus.dp, bus.frame_done, e[16:9], e[8:2], e[1], e[0]);
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] eAn, input logic [6:0] eSeg,
                     input logic eDp, input logic eFd);
    total++;
    if (bus.an !== eAn || bus.seg !== eSeg || bus.dp !== eDp || bus.frame_done !== eFd) begin
      bad++;
      $display("FAIL %s got an=%h seg=%h dp=%b fd=%b want an=%h seg=%h dp=%b fd=%b",
               nm, bus.an, bus.seg, bus.dp, bus.frame_done, eAn, eSeg, eDp, eFd);
    end
  endtask

  task automatic goTo(input int k);
    int guard = 0;
    while (mCyc != k && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (mCyc != k) begin
      total++;
      bad++;
      $display("FAIL goto got cyc=%0d want cyc=%0d", mCyc, k);
    end
  endtask

  task automatic drive(input logic ld, input logic [31:0] h, input logic [7:0] m);
    #1;
    bus.load    = ld;
    bus.hex     = h;
    bus.dp_mask = m;
  endtask

  task automatic loadAt(input int k, input logic [31:0] h, input logic [7:0] m);
    goTo(k);
    drive(1'b1, h, m);
    goTo(k + 1);
    drive(1'b0, 32'h0, 8'h0);
  endtask

  initial begin
    bus.load = 1'b0;
    bus.hex = '0;
    bus.dp_mask = '0;
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    cmpEn = 1'b1;
    chk("reset", 8'hFE, 7'h40, 1'b1, 1'b0);
    #1 reset = 1'b0;

    goTo(3);  chk("pre_tick", 8'hFE, 7'h40, 1'b1, 1'b0);
    goTo(4);  chk("first_adv", 8'hFD, 7'h40, 1'b1, 1'b0);
    drive(1'b1, 32'h12345678, 8'h01);
    goTo(5);  drive(1'b0, 32'h0, 8'h0);
    goTo(31); chk("pre_wrap", 8'h7F, 7'h40, 1'b1, 1'b0);
    goTo(32); chk("commit", 8'hFE, 7'h00, 1'b0, 1'b1);
    goTo(33); chk("fd_one_cycle", 8'hFE, 7'h00, 1'b0, 1'b0);
    goTo(36); chk("digit1", 8'hFD, 7'h78, 1'b1, 1'b0);

    loadAt(40, 32'hAAAAAAAA, 8'h00);
    loadAt(50, 32'h0000000F, 8'h00);
    goTo(64); chk("latest_wins", 8'hFE, 7'h0E, 1'b1, 1'b1);
    goTo(68);
`ifdef SEG7_SCANNER_LZB_EN
    chk("latest_d1", 8'hFF, 7'h7F, 1'b1, 1'b0);
`else
    chk("latest_d1", 8'hFD, 7'h40, 1'b1, 1'b0);
`endif

    loadAt(70, 32'h11111111, 8'h00);
    goTo(95); drive(1'b1, 32'h22222222, 8'hFF);
    goTo(96); chk("edge_old", 8'hFE, 7'h79, 1'b1, 1'b1);
    drive(1'b0, 32'h0, 8'h0);
    goTo(128); chk("edge_new", 8'hFE, 7'h24, 1'b0, 1'b1);

    loadAt(130, 32'h99999999, 8'hFF);
    goTo(148); chk("slot5", 8'hDF, 7'h24, 1'b0, 1'b0);
    #1 reset = 1'b1;
    #1 chk("reset_async", 8'hFE, 7'h40, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    goTo(32); chk("pending_dropped", 8'hFE, 7'h40, 1'b1, 1'b1);

    loadAt(40, 32'h000000A5, 8'h00);
    goTo(64); chk("lzb_d0", 8'hFE, 7'h12, 1'b1, 1'b1);
    goTo(68); chk("lzb_d1", 8'hFD, 7'h08, 1'b1, 1'b0);
    loadAt(70, 32'h00000000, 8'h00);
    goTo(72);
`ifdef SEG7_SCANNER_LZB_EN
    chk("lzb_d2", 8'hFF, 7'h7F, 1'b1, 1'b0);
`else
    chk("lzb_d2", 8'hFB, 7'h40, 1'b1, 1'b0);
`endif
    goTo(96); chk("zero_d0", 8'hFE, 7'h40, 1'b1, 1'b1);

    loadAt(100, 32'h0F1E2D3C, 8'hA5);
    loadAt(140, 32'hFEDCBA98, 8'h3C);
    goTo(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seg7_scanner.md
SEG7_SCANNER -- requirements
Module: seg7_scanner

Interface
REQ-001 SHALL have parameter CLK_DIV, default 16: clk cycles per digit slot; legal range is 2..65535.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port hex  input  32  display word from the CPU's syscall display output; nibble n drives digit n.
REQ-005 SHALL have port dp_mask  input  8  decimal-point request per digit, 1 = point lit.
REQ-006 SHALL have port load  input  1  single-cycle strobe that captures hex and dp_mask.
REQ-007 SHALL have port an  output  8  digit enables, active-low; an[0] is the rightmost digit.
REQ-008 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-009 SHALL have port dp  output  1  decimal point, active-low.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse at each frame commit boundary.

Function
REQ-011 SHALL run a prescaler counting 0..CLK_DIV-1 and wrapping to 0; tick = (prescaler == CLK_DIV-1).
REQ-012 SHALL run a 3-bit digit counter that advances on tick and wraps 7->0, so one frame = 8*CLK_DIV cycles.
REQ-013 SHALL hold a pending register (32+8 bits) and pending_valid; on load it captures hex/dp_mask and sets pending_valid, and the latest load wins.
REQ-014 SHALL hold a display register; on the edge where digit wraps 7->0 with pending_valid=1, it copies the pre-edge pending value into the display register and clears pending_valid.
REQ-015 SHALL, when load coincides with a commit edge, commit the old pending contents and store the new load in pending with pending_valid=1.
REQ-016 SHALL pulse frame_done high for exactly the one cycle following every 7->0 wrap, whether or not a commit occurred.
REQ-017 SHALL register an, seg and dp; they take the values for the new digit on the same edge that the digit advances.
REQ-018 SHALL drive an low on exactly one bit (bit = digit) and high on all others, except as blanked per REQ-026.
REQ-019 SHALL drive seg as the decode of the display nibble using hex 0-F -> 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E.
REQ-020 SHALL drive dp = ~dp_mask[digit] from the display register.
REQ-021 SHALL change no display output other than at a digit advance, so the display never tears mid-frame.

Reset
REQ-022 SHALL, while reset is asserted, clear prescaler, digit counter, pending register, pending_valid and display register to 0.
REQ-023 SHALL, while reset is asserted, hold an=8'hFE, seg=7'h40, dp=1 and frame_done=0.
REQ-024 SHALL, on reset assertion mid-frame, abort the frame and discard the pending value.
REQ-025 SHALL start the first slot after reset release, with the first tick CLK_DIV cycles after release.

Configuration
REQ-026 SHALL, with SEG7_SCANNER_LZB_EN defined, blank every digit above the most significant nonzero nibble of the display register (an stays 1, seg=7'h7F, dp=1).
REQ-027 SHALL, with SEG7_SCANNER_LZB_EN defined, never blank digit 0, so a value of 0 shows a single "0".
REQ-028 SHALL, without SEG7_SCANNER_LZB_EN, light all eight digits, with no blanking logic present.

Verification (CLK_DIV=4, frame = 32 cycles)
REQ-029 SHALL cover: reset pulse -> an=FE, seg=40, dp=1, frame_done=0; the first an change occurs 4 cycles after release.
REQ-030 SHALL cover: load 0x12345678, dp_mask=0x01 at cycle 5 -> display unchanged until the 7->0 wrap at cycle 32; then an=FE, seg=00, dp=0, frame_done high for one cycle.
REQ-031 SHALL cover: loads of 0xAAAAAAAA then 0x0000000F in the same frame -> the next frame shows only 0x0000000F (digit 0 seg=0E).
REQ-032 SHALL cover: load asserted on the commit edge -> the old pending value is shown this frame and the new value the next frame.
REQ-033 SHALL cover: reset asserted at slot 5 with a pending load -> outputs return to reset values and the pending value is never displayed.
REQ-034 SHALL cover: with SEG7_SCANNER_LZB_EN, load 0x000000A5 -> an[7:2] never go low; digits 0/1 show seg=12/08; load 0 -> only digit 0 lit with seg=40.
